// File: rtl/jam_cost_table_if.sv
// Bus between the JAM cost table and its host/solver: load stream, lookup port,
// result capture and synchronous clear.
interface jam_cost_table_if #(
    parameter int COST_W = 7,
    parameter int N      = 8,
    parameter int SUM_W  = 10
);
    localparam int IDX_W = $clog2(N);

    logic              clear;
    logic              load_valid;
    logic              load_ready;
    logic [COST_W-1:0] load_data;
    logic              table_ready;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [SUM_W-1:0]  MinCost;
    logic [3:0]        MatchCount;
    logic              result_valid;
    logic [SUM_W-1:0]  result_cost;
    logic [3:0]        result_count;

    modport master (
        output clear, load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        input  load_ready, table_ready, Cost, result_valid, result_cost, result_count
    );

    modport slave (
        input  clear, load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        output load_ready, table_ready, Cost, result_valid, result_cost, result_count
    );
endinterface

// File: rtl/jam_cost_table.sv
// JAM cost table: loads an NxN cost matrix, serves Cost[W][J] to the solver, captures its result.
// Optional parity protection of stored entries via macro JAM_COST_TABLE_PARITY_EN.
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int N      = 8,
    parameter int SUM_W  = 10
) (
    input  logic CLK,
    input  logic RST_n,
`ifdef JAM_COST_TABLE_PARITY_EN
    output logic parity_err,
`endif
    jam_cost_table_if.slave bus
);
    localparam int DEPTH  = N * N;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE,
        DONE
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic               loadReady_q;
    logic               tableReady_q;
    logic               resultValid_q;
    logic [SUM_W-1:0]   resultCost_q;
    logic [3:0]         resultCount_q;

    logic [COST_W-1:0]  mem [DEPTH];
    logic               writeEn;
    logic               lastEntry;
    logic [ADDR_W-1:0]  readIdx;
    logic [COST_W-1:0]  readWord;

    // loadReady_q is only ever high in LOAD, so it doubles as the state qualifier.
    assign writeEn   = !bus.clear && loadReady_q && bus.load_valid;
    assign lastEntry = (addr_q == ADDR_W'(DEPTH - 1));
    assign addr_d    = addr_q + ADDR_W'(1);
    assign readIdx   = {bus.W, bus.J};
    assign readWord  = mem[readIdx];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            loadReady_q   <= 1'b0;
            tableReady_q  <= 1'b0;
            resultValid_q <= 1'b0;
            resultCost_q  <= '0;
            resultCount_q <= '0;
        end else if (bus.clear) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            loadReady_q   <= 1'b0;
            tableReady_q  <= 1'b0;
            resultValid_q <= 1'b0;
            resultCost_q  <= '0;
            resultCount_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q     <= LOAD;
                    loadReady_q <= 1'b1;
                end
                LOAD: begin
                    if (bus.load_valid) begin
                        if (lastEntry) begin
                            state_q      <= SERVE;
                            addr_q       <= '0;
                            loadReady_q  <= 1'b0;
                            tableReady_q <= 1'b1;
                        end else begin
                            addr_q <= addr_d;
                        end
                    end
                end
                SERVE: begin
                    if (bus.Valid) begin
                        state_q       <= DONE;
                        resultValid_q <= 1'b1;
                        resultCost_q  <= bus.MinCost;
                        resultCount_q <= bus.MatchCount;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef JAM_COST_TABLE_PARITY_EN
    logic [DEPTH-1:0] parMem_q;
    logic             parityErr_q;
    logic             readMismatch;

    always_ff @(posedge CLK) begin
        if (writeEn) begin
            mem[addr_q]      <= bus.load_data;
            parMem_q[addr_q] <= ^bus.load_data;
        end
    end

    // Even parity: a stored bit that disagrees with the data's XOR flags corruption.
    assign readMismatch = tableReady_q && ((^readWord) != parMem_q[readIdx]);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            parityErr_q <= 1'b0;
        end else if (bus.clear) begin
            parityErr_q <= 1'b0;
        end else if (readMismatch) begin
            parityErr_q <= 1'b1;
        end
    end

    assign parity_err = parityErr_q;
`else
    always_ff @(posedge CLK) begin
        if (writeEn) begin
            mem[addr_q] <= bus.load_data;
        end
    end
`endif

    // Cost is combinational: the solver accumulates it in the same cycle it drives W/J.
    assign bus.Cost         = tableReady_q ? readWord : '0;
    assign bus.load_ready   = loadReady_q;
    assign bus.table_ready  = tableReady_q;
    assign bus.result_valid = resultValid_q;
    assign bus.result_cost  = resultCost_q;
    assign bus.result_count = resultCount_q;
endmodule

// File: tb/tb_jam_cost_table.sv
// Self-checking bench for jam_cost_table: table-driven lookups with a Cost scoreboard
// plus hand-written sequences for load, result capture, clear and reset corner cases.
module tb_jam_cost_table;
    localparam int COST_W = 7;
    localparam int N      = 8;
    localparam int SUM_W  = 10;

    typedef struct {
        int w;
        int j;
        int cost;
    } vec_t;

    logic CLK   = 1'b0;
    logic RST_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   expQ[$];
    vec_t vecs[8];
    int   xfers;
    int   rdy;

    jam_cost_table_if #(.COST_W(COST_W), .N(N), .SUM_W(SUM_W)) bus ();

`ifdef JAM_COST_TABLE_PARITY_EN
    logic parity_err;
    logic flipBit;
`endif

    jam_cost_table #(.COST_W(COST_W), .N(N), .SUM_W(SUM_W)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
`ifdef JAM_COST_TABLE_PARITY_EN
        .parity_err (parity_err),
`endif
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int w, input int j, input int expected);
        bus.W = 3'(w);
        bus.J = 3'(j);
        expQ.push_back(expected);
    endtask

    task automatic checkOutput(input string name);
        int e;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected nothing queued", name, int'(bus.Cost));
        end else begin
            e = expQ.pop_front();
            checkVal(name, int'(bus.Cost), e);
        end
    endtask

    task automatic readEntry(input int w, input int j, input int expected);
        @(posedge CLK);
        #1;
        applyStimulus(w, j, expected);
        @(negedge CLK);
        checkOutput($sformatf("cost w%0d j%0d", w, j));
    endtask

    // Drives the stream until 'limit' transfers are seen or the cycle budget runs out.
    task automatic loadTable(input int offset, input bit toggle, input int limit,
                             output int nXfer, output int nReady);
        int cyc;
        nXfer  = 0;
        nReady = 0;
        cyc    = 0;
        while (nXfer < limit && cyc < 400) begin
            @(posedge CLK);
            #1;
            bus.load_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.load_data  = COST_W'((nXfer + offset) % 128);
            @(negedge CLK);
            if (bus.load_ready) nReady++;
            if (bus.load_ready && bus.load_valid) nXfer++;
            cyc++;
        end
        @(posedge CLK);
        #1;
        bus.load_valid = 1'b0;
    endtask

    initial begin
        bus.clear      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.W          = '0;
        bus.J          = '0;
        bus.Valid      = 1'b0;
        bus.MinCost    = '0;
        bus.MatchCount = '0;

        vecs[0] = '{3, 5, 29};
        vecs[1] = '{7, 7, 63};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{1, 2, 10};
        vecs[4] = '{4, 0, 32};
        vecs[5] = '{6, 3, 51};
        vecs[6] = '{2, 7, 23};
        vecs[7] = '{5, 5, 45};

        #2;
        checkVal("reset load_ready", int'(bus.load_ready), 0);
        checkVal("reset table_ready", int'(bus.table_ready), 0);
        checkVal("reset result_valid", int'(bus.result_valid), 0);
        checkVal("reset result_cost", int'(bus.result_cost), 0);
        checkVal("reset result_count", int'(bus.result_count), 0);
        checkVal("reset Cost", int'(bus.Cost), 0);
        #10;
        RST_n = 1'b1;

        loadTable(0, 1'b0, 64, xfers, rdy);
        checkVal("load1 transfers", xfers, 64);
        checkVal("load1 ready cycles", rdy, 64);
        @(negedge CLK);
        checkVal("load1 table_ready", int'(bus.table_ready), 1);
        checkVal("load1 load_ready after", int'(bus.load_ready), 0);

        foreach (vecs[i]) readEntry(vecs[i].w, vecs[i].j, vecs[i].cost);

        @(posedge CLK);
        #1;
        bus.load_valid = 1'b1;
        bus.load_data  = 7'd127;
        @(negedge CLK);
        checkVal("serve load_ready", int'(bus.load_ready), 0);
        @(posedge CLK);
        #1;
        bus.load_valid = 1'b0;
        readEntry(0, 0, 0);
        readEntry(0, 1, 1);

        @(posedge CLK);
        #1;
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd345;
        bus.MatchCount = 4'd2;
        @(negedge CLK);
        checkVal("result_valid before capture", int'(bus.result_valid), 0);
        @(posedge CLK);
        #1;
        bus.Valid = 1'b0;
        @(negedge CLK);
        checkVal("result_valid", int'(bus.result_valid), 1);
        checkVal("result_cost", int'(bus.result_cost), 345);
        checkVal("result_count", int'(bus.result_count), 2);

        @(posedge CLK);
        #1;
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd100;
        bus.MatchCount = 4'd5;
        @(posedge CLK);
        #1;
        bus.Valid = 1'b0;
        @(negedge CLK);
        checkVal("done result_cost kept", int'(bus.result_cost), 345);
        checkVal("done result_count kept", int'(bus.result_count), 2);
        checkVal("done table_ready", int'(bus.table_ready), 1);
        readEntry(6, 3, 51);

        @(posedge CLK);
        #1;
        bus.clear   = 1'b1;
        bus.Valid   = 1'b1;
        bus.MinCost = 10'd77;
        applyStimulus(3, 5, 0);
        @(posedge CLK);
        #1;
        bus.clear = 1'b0;
        bus.Valid = 1'b0;
        @(negedge CLK);
        checkVal("clear result_valid", int'(bus.result_valid), 0);
        checkVal("clear result_cost", int'(bus.result_cost), 0);
        checkVal("clear result_count", int'(bus.result_count), 0);
        checkVal("clear table_ready", int'(bus.table_ready), 0);
        checkVal("clear load_ready idle", int'(bus.load_ready), 0);
        checkOutput("clear Cost");
        @(posedge CLK);
        @(negedge CLK);
        checkVal("clear then load_ready", int'(bus.load_ready), 1);

        loadTable(0, 1'b1, 64, xfers, rdy);
        checkVal("load2 transfers", xfers, 64);
        @(negedge CLK);
        checkVal("load2 table_ready", int'(bus.table_ready), 1);
        readEntry(7, 7, 63);
        readEntry(0, 0, 0);

        @(posedge CLK);
        #1;
        bus.clear = 1'b1;
        @(posedge CLK);
        #1;
        bus.clear = 1'b0;
        loadTable(100, 1'b0, 30, xfers, rdy);
        checkVal("partial transfers", xfers, 30);
        RST_n = 1'b0;
        #3;
        checkVal("mid-load reset table_ready", int'(bus.table_ready), 0);
        checkVal("mid-load reset load_ready", int'(bus.load_ready), 0);
        @(negedge CLK);
        #2;
        RST_n = 1'b1;
        loadTable(50, 1'b0, 64, xfers, rdy);
        checkVal("reload transfers", xfers, 64);
        checkVal("reload ready cycles", rdy, 64);
        @(negedge CLK);
        checkVal("reload table_ready", int'(bus.table_ready), 1);
        for (int k = 0; k < 64; k += 7) readEntry(k / 8, k % 8, (k + 50) % 128);
        readEntry(7, 7, (63 + 50) % 128);

`ifdef JAM_COST_TABLE_PARITY_EN
        checkVal("parity_err clean", int'(parity_err), 0);
        flipBit = ~(^COST_W'(60));
        force dut.parMem_q[10] = flipBit;
        readEntry(1, 2, 60);
        @(posedge CLK);
        #1;
        bus.W = 3'd0;
        bus.J = 3'd0;
        @(negedge CLK);
        checkVal("parity_err set", int'(parity_err), 1);
        release dut.parMem_q[10];
        @(posedge CLK);
        @(negedge CLK);
        checkVal("parity_err sticky", int'(parity_err), 1);
        @(posedge CLK);
        #1;
        bus.clear = 1'b1;
        @(posedge CLK);
        #1;
        bus.clear = 1'b0;
        @(negedge CLK);
        checkVal("parity_err cleared", int'(parity_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Responder end of the JAM job-assignment interface. Stores the 8x8 worker/job cost matrix and returns Cost for each requested (W, J) pair.
- Captures the solver's final MinCost/MatchCount when Valid fires.
- The matrix is loaded by a host over a valid/ready stream before the solver runs. Sits between the host/loader and the JAM solver in the contest top level.

Parameters:
- COST_W, 7, width of one cost entry.
- N, 8, workers = jobs; matrix has N*N entries, W/J width is log2(N).
- SUM_W, 10, width of captured MinCost (must hold N*(2^COST_W-1)).

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- load_valid  in  1  host offers load_data.
- load_ready  out  1  block accepts load_data this cycle.
- load_data  in  COST_W  cost entry, row-major order (W major, J minor).
- clear  in  1  synchronous pulse: discard table and result, return to IDLE.
- table_ready  out  1  matrix fully loaded; solver may start.
- W  in  3  worker index from solver.
- J  in  3  job index from solver.
- Cost  out  COST_W  cost of (W, J).
- Valid  in  1  solver result strobe.
- MinCost  in  SUM_W  solver minimum cost.
- MatchCount  in  4  solver count of minimum assignments.
- result_valid  out  1  captured result held.
- result_cost  out  SUM_W  captured MinCost.
- result_count  out  4  captured MatchCount.

Behaviour:
- FSM states: IDLE, LOAD, SERVE, DONE. Reset state is IDLE.
- Reset values: load_ready=0, table_ready=0, result_valid=0, result_cost=0, result_count=0, Cost=0, address counter=0. Reset mid-load discards all progress; memory contents are don't-care after reset.
- IDLE -> LOAD on the next cycle, unconditionally. load_ready=1 only in LOAD.
- LOAD:
  - A transfer occurs when load_valid && load_ready. It writes mem[addr] = load_data and increments addr (6-bit).
  - On the 64th transfer (addr==63), go to SERVE and reset addr to 0. No wrap into a second pass.
  - load_valid low stalls with no state change.
- SERVE:
  - table_ready=1.
  - Cost = mem[{W,J}] combinationally, same cycle, because the solver accumulates Cost in the cycle it drives W/J.
  - In every state other than SERVE and DONE, Cost=0.
  - Valid high in SERVE: register MinCost and MatchCount into result_cost and result_count, set result_valid=1 the following cycle, go to DONE.
- DONE:
  - table_ready stays 1 and Cost is still served.
  - Further Valid pulses are ignored; the first result is kept.
- clear:
  - Takes priority over all events in the same cycle, including a load transfer or Valid.
  - Next state is IDLE; table_ready, result_valid, result_cost, result_count and addr go to 0.
- load_valid outside LOAD is ignored. No data is consumed and memory is unchanged.

Optional Feature:
- Macro JAM_COST_TABLE_PARITY_EN.
- When defined:
  - Each entry stores an extra even-parity bit computed at write.
  - Extra output parity_err (1 bit, reset 0) is a sticky flag. It sets when a SERVE/DONE read finds a stored parity mismatch with the entry, and is cleared only by reset or clear.
  - The bench can inject a fault through a hierarchical force on a parity bit.
- When not defined: no parity storage and no parity_err port. All other behaviour is identical.

Test Plan:
- Reset then load 64 entries with mem[w*8+j] = (w*8+j) mod 128, load_valid held high -> load_ready high for exactly 64 cycles; table_ready=1 on the cycle after the 64th transfer; W=3,J=5 gives Cost=29 in the same cycle.
- Load with load_valid toggling every other cycle -> still exactly 64 entries accepted; W=7,J=7 gives Cost=63; W=0,J=0 gives Cost=0.
- In SERVE, Valid=1 with MinCost=10'd345 and MatchCount=4'd2 -> next cycle result_valid=1, result_cost=345, result_count=2; a later Valid with MinCost=100 leaves the result unchanged.
- Assert RST_n low after 30 load transfers, release, reload 64 entries -> table_ready asserts only after the full 64 new transfers; Cost reflects new data.
- clear in DONE on the same cycle as Valid -> next cycle state IDLE, result_valid=0, table_ready=0, Cost=0, then load_ready=1 one cycle later.
- With JAM_COST_TABLE_PARITY_EN: force a flipped parity bit on entry 10, read W=1,J=2 -> parity_err=1 next cycle and stays 1 until clear.
